// File: rtl/pc_fetch_queue.sv
// Fetch front-end: owns the PC, issues in-order imem requests and buffers returned words with
// their PCs in a DEPTH-entry queue; redirect flushes the queue and drops responses still in flight.
module pc_fetch_queue #(
  parameter int              PC_W     = 14,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clkEn,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  output logic [PC_W-1:0]          imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_W-1:0] STEP  = PC_W'(PC_STEP);
  localparam logic [AW-1:0]   ONE_A = AW'(1);
  localparam logic [CW-1:0]   ONE_C = CW'(1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]   count_q, count_d, pend_q, pend_d, disc_q, disc_d;
  logic [CW:0]     inflight;
  logic [PC_W-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic redir, acc, fill, deq;

  assign redir          = clkEn && redirect_valid;
  // Gated by rst so every handshake output reads 0 while reset is held.
  assign imem_req_valid = !rst && clkEn && !redirect_valid && (count_q < CW'(DEPTH));
  assign acc            = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && (disc_q == '0) && (pend_q != '0);
  assign out_valid      = !rst && clkEn && filled_q[head_q];
  assign deq            = out_valid && out_ready && !redir;

  assign imem_req_addr  = pc_q;
  assign out_pc         = pc_mem_q[head_q];
  assign out_instr      = instr_mem_q[head_q];
  assign q_count        = count_q;

  always_comb begin
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q;
    pend_d   = pend_q;
    disc_d   = disc_q;
    inflight = '0;
    if (redir) begin
      pc_d    = redirect_pc & ~PC_W'(3);
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
      // Everything still owed by memory must be dropped, including a word arriving right now.
      inflight = {1'b0, disc_q} + {1'b0, pend_q};
      if (imem_rsp_valid && (inflight != '0)) inflight = inflight - (CW+1)'(1);
      disc_d = inflight[CW-1:0];
    end else begin
      if (acc) begin
        pc_d   = pc_q + STEP;
        tail_d = tail_q + ONE_A;
      end
      if (deq)  head_d = head_q + ONE_A;
      if (fill) fill_d = fill_q + ONE_A;
      count_d = count_q + CW'(acc) - CW'(deq);
      pend_d  = pend_q + CW'(acc) - CW'(fill);
      if (imem_rsp_valid && (disc_q != '0)) disc_d = disc_q - ONE_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      disc_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      disc_q  <= disc_d;
      if (redir) begin
        filled_q <= '0;
      end else begin
        if (acc) begin
          pc_mem_q[tail_q] <= pc_q;
          filled_q[tail_q] <= 1'b0;
        end
        if (fill) begin
          instr_mem_q[fill_q] <= imem_rsp_data;
          filled_q[fill_q]    <= 1'b1;
        end
        if (deq) filled_q[head_q] <= 1'b0;
      end
    end
  end

endmodule
